topw_stream_sort: RTL

Streaming top-W selector, sequential successor of the parallel max-sort wrapper. Accepts one N-bit element per beat over a valid/ready stream. Keeps a running sorted list of the W largest (or smallest) values plus their in-frame indices, and presents the list on a valid/ready output port at frame end. Sits between the sample source and downstream consumers; frame length is runtime-variable, marked by i_last.

---
 rtl/topw_stream_sort.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/topw_stream_sort.sv
// rtl/topw_stream_sort.sv - streaming top-W selector with per-frame sorted result list
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid/i_ready input beat handshake; i_data element, i_last marks frame end
//   o_valid/o_ready result handshake; held stable until taken
//   o_data          W slots of N bits, slot s at [s*N +: N], slot 0 is best rank
//   o_idx           W slots of IDXW bits, in-frame beat index of each slot
//   o_count         number of filled slots
//   o_overflow      frame was longer than 2^IDXW beats
module topw_stream_sort #(
    parameter int N        = 16,
    parameter int W        = 4,
    parameter int IDXW     = 8,
    parameter int MODE_MIN = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [N-1:0]           i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [W*N-1:0]         o_data,
    output logic [W*IDXW-1:0]      o_idx,
    output logic [$clog2(W+1)-1:0] o_count,
    output logic                   o_overflow
);

    localparam int CW = $clog2(W + 1);
    localparam logic [IDXW-1:0] IDX_MAX = '1;

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]    val_q [W];
    logic [IDXW-1:0] idx_q [W];
    logic [W-1:0]    fill_q;
    logic [IDXW-1:0] cnt_q;
    logic            cnt_full_q;  // the last index value has been handed out
    logic            ovf_q;
    logic            ready_q;

    logic [N-1:0]    val_d [W];
    logic [IDXW-1:0] idx_d [W];
    logic [W-1:0]    fill_d;
    logic [W-1:0]    better;
    logic [CW-1:0]   rank;
    logic [CW-1:0]   fill_cnt;

    logic accept;
    logic take;

    // ready is registered so it stays low through reset and rises on the
    // first clock after release.
    assign accept  = i_valid && ready_q;
    assign take    = (state_q == ST_OUT) && o_ready;
    assign i_ready = ready_q;
    assign o_valid = (state_q == ST_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && i_last) state_d = ST_OUT;
            ST_OUT:  if (o_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // An existing entry that ties with the new element counts as better, so
    // earlier arrivals keep the higher rank. The filled slots are a sorted
    // prefix, so the count of better slots is the insertion position.
    always_comb begin
        better = '0;
        rank   = '0;
        for (int s = 0; s < W; s++) begin
            if (MODE_MIN != 0) begin
                better[s] = fill_q[s] && (val_q[s] <= i_data);
            end else begin
                better[s] = fill_q[s] && (val_q[s] >= i_data);
            end
            if (better[s]) rank = rank + CW'(1);
        end
    end

    // Slots above the rank keep their entry, the rank slot takes the new
    // element, slots below shift down one; a rank of W or more matches no slot.
    always_comb begin
        fill_d = fill_q;
        for (int s = 0; s < W; s++) begin
            val_d[s] = val_q[s];
            idx_d[s] = idx_q[s];
        end
        for (int s = 0; s < W; s++) begin
            if (CW'(s) == rank) begin
                val_d[s]  = i_data;
                idx_d[s]  = cnt_q;
                fill_d[s] = 1'b1;
            end else if (CW'(s) > rank) begin
                val_d[s]  = val_q[(s > 0) ? s - 1 : 0];
                idx_d[s]  = idx_q[(s > 0) ? s - 1 : 0];
                fill_d[s] = fill_q[(s > 0) ? s - 1 : 0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            fill_q     <= '0;
            cnt_q      <= '0;
            cnt_full_q <= 1'b0;
            ovf_q      <= 1'b0;
            for (int s = 0; s < W; s++) begin
                val_q[s] <= '0;
                idx_q[s] <= '0;
            end
        end else begin
            ready_q <= (state_d == ST_ACC);
            if (take) begin
                fill_q     <= '0;
                cnt_q      <= '0;
                cnt_full_q <= 1'b0;
                ovf_q      <= 1'b0;
                for (int s = 0; s < W; s++) begin
                    val_q[s] <= '0;
                    idx_q[s] <= '0;
                end
            end else if (accept) begin
                fill_q <= fill_d;
                for (int s = 0; s < W; s++) begin
                    val_q[s] <= val_d[s];
                    idx_q[s] <= idx_d[s];
                end
                // The counter holds at its maximum; only a beat arriving after
                // the maximum index was already used means the frame overran.
                if (cnt_full_q) begin
                    ovf_q <= 1'b1;
                end else if (cnt_q == IDX_MAX) begin
                    cnt_full_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + IDXW'(1);
                end
            end
        end
    end

    always_comb begin
        fill_cnt = '0;
        for (int s = 0; s < W; s++) begin
            if (fill_q[s]) fill_cnt = fill_cnt + CW'(1);
        end
    end

    always_comb begin
        o_data = '0;
        o_idx  = '0;
        for (int s = 0; s < W; s++) begin
            if (o_valid && fill_q[s]) begin
                o_data[s*N +: N]       = val_q[s];
                o_idx[s*IDXW +: IDXW]  = idx_q[s];
            end
        end
    end

    assign o_count    = o_valid ? fill_cnt : '0;
    assign o_overflow = o_valid && ovf_q;

endmodule
